// File: rtl/frogger_game_fsm_if.sv
// Game-state controller bundle: player/environment events in, game status out.
// The controller attaches through the slave modport. The stimulus or upstream
// side attaches through the master modport.
interface frogger_game_fsm_if;
    logic       i_Start;
    logic       i_Collided;
    logic       i_Drowned;
    logic [6:0] i_Score;
    logic       o_Game_Active;
    logic [2:0] o_Lives;
    logic [2:0] o_Level;
    logic [2:0] o_State;
    logic       o_Score_Clr;
    logic       o_Death_Pulse;
    logic       o_Game_Over;

    modport slave (
        input  i_Start, i_Collided, i_Drowned, i_Score,
        output o_Game_Active, o_Lives, o_Level, o_State,
        output o_Score_Clr, o_Death_Pulse, o_Game_Over
    );

    modport master (
        output i_Start, i_Collided, i_Drowned, i_Score,
        input  o_Game_Active, o_Lives, o_Level, o_State,
        input  o_Score_Clr, o_Death_Pulse, o_Game_Over
    );
endinterface

// File: rtl/frogger_game_fsm.sv
// Frogger game-state controller.
// This block sequences the game through IDLE, PLAYING, DYING, LEVEL_UP, OVER and WIN.
// It tracks lives, the level and the per-level score target.
// It also times the death and level-up freezes.
// Optional build macro FROGGER_EXTRA_LIFE_EN: when defined, every level-up
// grants one extra life, saturating at 7.
// Output pulses are registered, so each one coincides with the first cycle of
// its new state.
module frogger_game_fsm #(
    parameter int c_LIVES         = 3,
    parameter int c_WIN_SCORE     = 2,
    parameter int c_FREEZE_CYCLES = 25000000,
    parameter int c_LEVEL_MAX     = 3
) (
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    frogger_game_fsm_if.slave  game
);

    localparam int c_CNT_W = $clog2(c_FREEZE_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PLAYING  = 3'd1,
        ST_DYING    = 3'd2,
        ST_LEVEL_UP = 3'd3,
        ST_OVER     = 3'd4,
        ST_WIN      = 3'd5
    } state_t;

    state_t               r_State, w_State_Next;
    logic [2:0]           r_Lives, w_Lives_Next;
    logic [2:0]           r_Level, w_Level_Next;
    logic [6:0]           r_Target, w_Target_Next;
    logic [c_CNT_W-1:0]   r_Count, w_Count_Next;
    logic                 r_Score_Clr, w_Score_Clr_Next;
    logic                 r_Death_Pulse, w_Death_Pulse_Next;
    logic                 r_Start;
    logic                 r_Armed;

    logic                 w_Start_Edge;
    logic                 w_Hit;
    logic                 w_Freeze_Done;
    logic [7:0]           w_Target_Sum;
    logic [6:0]           w_Target_Inc;

    // r_Armed stays low for the first clock after reset release.
    // During that clock r_Start loads the current switch level.
    // As a result, a switch already held high through reset does not start a game.
    assign w_Start_Edge  = game.i_Start & ~r_Start & r_Armed;
    assign w_Hit         = game.i_Collided | game.i_Drowned;
    assign w_Freeze_Done = (r_Count == c_CNT_W'(c_FREEZE_CYCLES - 1));
    assign w_Target_Sum  = {1'b0, r_Target} + 8'(c_WIN_SCORE);
    assign w_Target_Inc  = w_Target_Sum[7] ? 7'd127 : w_Target_Sum[6:0];

`ifdef FROGGER_EXTRA_LIFE_EN
    logic [2:0] w_Lives_Inc;
    assign w_Lives_Inc = (r_Lives == 3'd7) ? r_Lives : r_Lives + 3'd1;
`endif

    // State and datapath registers; an asynchronous reset aborts any freeze at once.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State       <= ST_IDLE;
            r_Lives       <= 3'(c_LIVES);
            r_Level       <= 3'd0;
            r_Target      <= 7'(c_WIN_SCORE);
            r_Count       <= '0;
            r_Score_Clr   <= 1'b0;
            r_Death_Pulse <= 1'b0;
            r_Start       <= 1'b0;
            r_Armed       <= 1'b0;
        end else begin
            r_State       <= w_State_Next;
            r_Lives       <= w_Lives_Next;
            r_Level       <= w_Level_Next;
            r_Target      <= w_Target_Next;
            r_Count       <= w_Count_Next;
            r_Score_Clr   <= w_Score_Clr_Next;
            r_Death_Pulse <= w_Death_Pulse_Next;
            r_Start       <= game.i_Start;
            r_Armed       <= 1'b1;
        end
    end

    // Next-state and datapath update for each game state.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_State_Next       = r_State;
        w_Lives_Next       = r_Lives;
        w_Level_Next       = r_Level;
        w_Target_Next      = r_Target;
        w_Count_Next       = r_Count;
        w_Score_Clr_Next   = 1'b0;
        w_Death_Pulse_Next = 1'b0;

        case (r_State)
            ST_IDLE, ST_OVER, ST_WIN: begin
                if (w_Start_Edge) begin
                    w_State_Next     = ST_PLAYING;
                    w_Lives_Next     = 3'(c_LIVES);
                    w_Level_Next     = 3'd1;
                    w_Target_Next    = 7'(c_WIN_SCORE);
                    w_Score_Clr_Next = 1'b1;
                end
            end

            ST_PLAYING: begin
                if (w_Hit) begin
                    // PLAYING always holds at least one life, so the guard never blocks a death.
                    if (r_Lives != 3'd0)
                        w_Lives_Next = r_Lives - 3'd1;
                    w_Death_Pulse_Next = 1'b1;
                    w_Count_Next       = '0;
                    w_State_Next       = ST_DYING;
                end else if (game.i_Score >= r_Target) begin
                    if (r_Level == 3'(c_LEVEL_MAX)) begin
                        w_State_Next = ST_WIN;
                    end else begin
                        w_Level_Next  = r_Level + 3'd1;
                        w_Target_Next = w_Target_Inc;
                        w_Count_Next  = '0;
                        w_State_Next  = ST_LEVEL_UP;
`ifdef FROGGER_EXTRA_LIFE_EN
                        w_Lives_Next  = w_Lives_Inc;
`endif
                    end
                end
            end

            ST_DYING: begin
                w_Count_Next = r_Count + c_CNT_W'(1);
                if (w_Freeze_Done)
                    w_State_Next = (r_Lives == 3'd0) ? ST_OVER : ST_PLAYING;
            end

            ST_LEVEL_UP: begin
                w_Count_Next = r_Count + c_CNT_W'(1);
                if (w_Freeze_Done)
                    w_State_Next = ST_PLAYING;
            end

            default: begin
                w_State_Next = ST_IDLE;
            end
        endcase
    end

    assign game.o_Game_Active = (r_State == ST_PLAYING);
    assign game.o_Game_Over   = (r_State == ST_OVER) || (r_State == ST_WIN);
    assign game.o_State       = r_State;
    assign game.o_Lives       = r_Lives;
    assign game.o_Level       = r_Level;
    assign game.o_Score_Clr   = r_Score_Clr;
    assign game.o_Death_Pulse = r_Death_Pulse;

endmodule

// File: tb/tb_frogger_game_fsm.sv
// Directed testbench for frogger_game_fsm with a short freeze (4 cycles).
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
module tb_frogger_game_fsm;

    logic i_Clk;
    logic i_Rst_L;
    int   checks;
    int   failures;

`ifdef FROGGER_EXTRA_LIFE_EN
    localparam int c_XL = 1;
`else
    localparam int c_XL = 0;
`endif

    frogger_game_fsm_if u_if ();

    frogger_game_fsm #(
        .c_LIVES         (3),
        .c_WIN_SCORE     (2),
        .c_FREEZE_CYCLES (4),
        .c_LEVEL_MAX     (3)
    ) u_dut (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .game    (u_if)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    // Reset mid-cycle, release, let the start detector arm, then start a game.
    task automatic reset_and_start();
        i_Rst_L          = 1'b0;
        u_if.i_Start     = 1'b0;
        u_if.i_Collided  = 1'b0;
        u_if.i_Drowned   = 1'b0;
        u_if.i_Score     = 7'd0;
        #3;
        i_Rst_L = 1'b1;
        tick();
        tick();
        u_if.i_Start = 1'b1;
        tick();
        u_if.i_Start = 1'b0;
    endtask

    task automatic die_and_wait();
        u_if.i_Collided = 1'b1;
        tick();
        u_if.i_Collided = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        i_Rst_L         = 1'b0;
        u_if.i_Start    = 1'b0;
        u_if.i_Collided = 1'b0;
        u_if.i_Drowned  = 1'b0;
        u_if.i_Score    = 7'd0;
        #12;
        checks++; if (u_if.o_State !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", u_if.o_State); end
        checks++; if (u_if.o_Lives !== 3'd3) begin failures++; $display("FAIL reset_lives got=%0d exp=3", u_if.o_Lives); end
        checks++; if (u_if.o_Level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", u_if.o_Level); end
        checks++; if ({u_if.o_Game_Active, u_if.o_Score_Clr, u_if.o_Death_Pulse, u_if.o_Game_Over} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000", {u_if.o_Game_Active, u_if.o_Score_Clr, u_if.o_Death_Pulse, u_if.o_Game_Over});
        end
        i_Rst_L = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_start();
        int pulses;
        pulses = 0;
        u_if.i_Start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (u_if.o_Score_Clr === 1'b1) pulses++;
            if (i == 0) begin
                checks++; if (u_if.o_State !== 3'd1) begin failures++; $display("FAIL start_state got=%0d exp=1", u_if.o_State); end
                checks++; if (u_if.o_Lives !== 3'd3) begin failures++; $display("FAIL start_lives got=%0d exp=3", u_if.o_Lives); end
                checks++; if (u_if.o_Level !== 3'd1) begin failures++; $display("FAIL start_level got=%0d exp=1", u_if.o_Level); end
                checks++; if (u_if.o_Game_Active !== 1'b1) begin failures++; $display("FAIL start_active got=%b exp=1", u_if.o_Game_Active); end
            end
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL start_clr_pulses got=%0d exp=1", pulses); end
        checks++; if (u_if.o_State !== 3'd1) begin failures++; $display("FAIL start_held_state got=%0d exp=1", u_if.o_State); end
        u_if.i_Start = 1'b0;
        tick();
    endtask

    task automatic test_death();
        reset_and_start();
        u_if.i_Collided = 1'b1;
        tick();
        u_if.i_Collided = 1'b0;
        checks++; if (u_if.o_Death_Pulse !== 1'b1) begin failures++; $display("FAIL death_pulse got=%b exp=1", u_if.o_Death_Pulse); end
        checks++; if (u_if.o_Lives !== 3'd2) begin failures++; $display("FAIL death_lives got=%0d exp=2", u_if.o_Lives); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (u_if.o_State !== 3'd2 || u_if.o_Game_Active !== 1'b0) begin
                failures++; $display("FAIL death_freeze_%0d got state=%0d active=%b exp state=2 active=0", i, u_if.o_State, u_if.o_Game_Active);
            end
            tick();
            if (i == 0) begin
                checks++; if (u_if.o_Death_Pulse !== 1'b0) begin failures++; $display("FAIL death_pulse_width got=%b exp=0", u_if.o_Death_Pulse); end
            end
        end
        checks++; if (u_if.o_State !== 3'd1) begin failures++; $display("FAIL death_resume got=%0d exp=1", u_if.o_State); end
        checks++; if (u_if.o_Lives !== 3'd2) begin failures++; $display("FAIL death_resume_lives got=%0d exp=2", u_if.o_Lives); end
    endtask

    task automatic test_game_over();
        reset_and_start();
        die_and_wait();
        die_and_wait();
        die_and_wait();
        checks++; if (u_if.o_State !== 3'd4) begin failures++; $display("FAIL over_state got=%0d exp=4", u_if.o_State); end
        checks++; if (u_if.o_Game_Over !== 1'b1) begin failures++; $display("FAIL over_flag got=%b exp=1", u_if.o_Game_Over); end
        checks++; if (u_if.o_Lives !== 3'd0) begin failures++; $display("FAIL over_lives got=%0d exp=0", u_if.o_Lives); end
        u_if.i_Collided = 1'b1;
        repeat (3) tick();
        u_if.i_Collided = 1'b0;
        checks++; if (u_if.o_State !== 3'd4 || u_if.o_Lives !== 3'd0 || u_if.o_Level !== 3'd1) begin
            failures++; $display("FAIL over_hold got state=%0d lives=%0d level=%0d exp 4/0/1", u_if.o_State, u_if.o_Lives, u_if.o_Level);
        end
        u_if.i_Start = 1'b1;
        tick();
        u_if.i_Start = 1'b0;
        checks++; if (u_if.o_State !== 3'd1 || u_if.o_Lives !== 3'd3 || u_if.o_Level !== 3'd1) begin
            failures++; $display("FAIL over_restart got state=%0d lives=%0d level=%0d exp 1/3/1", u_if.o_State, u_if.o_Lives, u_if.o_Level);
        end
        checks++; if (u_if.o_Score_Clr !== 1'b1 || u_if.o_Game_Over !== 1'b0) begin
            failures++; $display("FAIL over_restart_flags got clr=%b over=%b exp clr=1 over=0", u_if.o_Score_Clr, u_if.o_Game_Over);
        end
    endtask

    task automatic test_level_up();
        reset_and_start();
        u_if.i_Score = 7'd1;
        tick();
        checks++; if (u_if.o_State !== 3'd1) begin failures++; $display("FAIL lvl_below_target got=%0d exp=1", u_if.o_State); end
        u_if.i_Score = 7'd2;
        tick();
        checks++; if (u_if.o_State !== 3'd3 || u_if.o_Level !== 3'd2) begin
            failures++; $display("FAIL lvl_up1 got state=%0d level=%0d exp 3/2", u_if.o_State, u_if.o_Level);
        end
        checks++; if (u_if.o_Lives !== 3'(3 + c_XL)) begin failures++; $display("FAIL lvl_up1_lives got=%0d exp=%0d", u_if.o_Lives, 3 + c_XL); end
        repeat (3) tick();
        checks++; if (u_if.o_State !== 3'd3) begin failures++; $display("FAIL lvl_freeze_end got=%0d exp=3", u_if.o_State); end
        tick();
        checks++; if (u_if.o_State !== 3'd1) begin failures++; $display("FAIL lvl_resume got=%0d exp=1", u_if.o_State); end
        u_if.i_Score = 7'd3;
        tick();
        checks++; if (u_if.o_State !== 3'd1) begin failures++; $display("FAIL lvl2_below_target got=%0d exp=1", u_if.o_State); end
        u_if.i_Score = 7'd4;
        tick();
        checks++; if (u_if.o_State !== 3'd3 || u_if.o_Level !== 3'd3) begin
            failures++; $display("FAIL lvl_up2 got state=%0d level=%0d exp 3/3", u_if.o_State, u_if.o_Level);
        end
        repeat (4) tick();
        u_if.i_Score = 7'd6;
        tick();
        checks++; if (u_if.o_State !== 3'd5 || u_if.o_Game_Over !== 1'b1) begin
            failures++; $display("FAIL lvl_win got state=%0d over=%b exp 5/1", u_if.o_State, u_if.o_Game_Over);
        end
        checks++; if (u_if.o_Level !== 3'd3 || u_if.o_Lives !== 3'(3 + 2 * c_XL)) begin
            failures++; $display("FAIL lvl_win_stats got level=%0d lives=%0d exp 3/%0d", u_if.o_Level, u_if.o_Lives, 3 + 2 * c_XL);
        end
        u_if.i_Score = 7'd0;
    endtask

    task automatic test_priority_and_reset();
        reset_and_start();
        u_if.i_Drowned = 1'b1;
        u_if.i_Score   = 7'd2;
        tick();
        u_if.i_Drowned = 1'b0;
        u_if.i_Score   = 7'd0;
        checks++; if (u_if.o_State !== 3'd2 || u_if.o_Level !== 3'd1 || u_if.o_Lives !== 3'd2) begin
            failures++; $display("FAIL prio got state=%0d level=%0d lives=%0d exp 2/1/2", u_if.o_State, u_if.o_Level, u_if.o_Lives);
        end
        u_if.i_Start = 1'b1;
        tick();
        checks++; if (u_if.o_State !== 3'd2 || u_if.o_Score_Clr !== 1'b0) begin
            failures++; $display("FAIL dying_start_ignored got state=%0d clr=%b exp 2/0", u_if.o_State, u_if.o_Score_Clr);
        end
        tick();
        i_Rst_L = 1'b0;
        #1;
        checks++; if (u_if.o_State !== 3'd0 || u_if.o_Lives !== 3'd3 || u_if.o_Level !== 3'd0) begin
            failures++; $display("FAIL async_reset got state=%0d lives=%0d level=%0d exp 0/3/0", u_if.o_State, u_if.o_Lives, u_if.o_Level);
        end
        checks++; if ({u_if.o_Game_Active, u_if.o_Death_Pulse, u_if.o_Game_Over} !== 3'b000) begin
            failures++; $display("FAIL async_reset_flags got=%b exp=000", {u_if.o_Game_Active, u_if.o_Death_Pulse, u_if.o_Game_Over});
        end
        #2;
        i_Rst_L = 1'b1;
        repeat (4) tick();
        checks++; if (u_if.o_State !== 3'd0 || u_if.o_Score_Clr !== 1'b0) begin
            failures++; $display("FAIL no_spurious_start got state=%0d clr=%b exp 0/0", u_if.o_State, u_if.o_Score_Clr);
        end
        u_if.i_Start = 1'b0;
        tick();
        u_if.i_Start = 1'b1;
        tick();
        u_if.i_Start = 1'b0;
        checks++; if (u_if.o_State !== 3'd1) begin failures++; $display("FAIL restart_after_reset got=%0d exp=1", u_if.o_State); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_start();
        test_death();
        test_game_over();
        test_level_up();
        test_priority_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
